// File: rtl/sweep_controller.sv
// rtl/sweep_controller.sv - up/down sweep counter between latched bounds with endpoint dwell
// and sweep-count limit.
module sweep_controller #(
  parameter int WIDTH   = 8,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [WIDTH-1:0]   cfg_lo,
  input  logic [WIDTH-1:0]   cfg_hi,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [7:0]         cfg_sweeps,
  input  logic               start,
  input  logic               stop,
  output logic [WIDTH-1:0]   count,
  output logic               down,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [2:0] {S_IDLE, S_UP, S_DWELL_HI, S_DOWN, S_DWELL_LO} state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_lo, r_hi, r_count, w_count_nxt;
  logic [DWELL_W-1:0] r_dwell, r_dwell_cnt, w_dwell_cnt_nxt;
  logic [7:0]         r_sweeps, r_sweep_cnt, w_sweep_cnt_nxt;
  logic               r_down, r_busy, r_done, r_cfg_err;
  logic               w_done_nxt, w_cfg_err_nxt, w_latch;

  logic [WIDTH-1:0]   w_count_inc, w_count_dec;
  logic [7:0]         w_sweep_inc;
  logic               w_accept, w_up_end, w_down_end, w_dwell_end, w_last, w_abort;

  assign w_count_inc = r_count + 1'b1;
  assign w_count_dec = r_count - 1'b1;
  assign w_sweep_inc = r_sweep_cnt + 8'd1;
  assign w_accept    = start && (cfg_lo < cfg_hi);
  assign w_up_end    = (w_count_inc == r_hi);
  assign w_down_end  = (w_count_dec == r_lo);
  assign w_dwell_end = (r_dwell_cnt == DWELL_W'(1));
  assign w_last      = (r_sweeps != 8'd0) && (w_sweep_inc == r_sweeps);
  assign w_abort     = stop && (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_lo        <= '0;
      r_hi        <= '0;
      r_dwell     <= '0;
      r_sweeps    <= '0;
      r_count     <= '0;
      r_dwell_cnt <= '0;
      r_sweep_cnt <= '0;
      r_down      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_dwell_cnt <= w_dwell_cnt_nxt;
      r_sweep_cnt <= w_sweep_cnt_nxt;
      r_down      <= (w_state_nxt == S_DWELL_HI) || (w_state_nxt == S_DOWN);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= w_done_nxt;
      r_cfg_err   <= w_cfg_err_nxt;
      if (w_latch) begin
        r_lo     <= cfg_lo;
        r_hi     <= cfg_hi;
        r_dwell  <= cfg_dwell;
        r_sweeps <= cfg_sweeps;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_state_nxt = S_UP;
      S_UP:       if (w_up_end) w_state_nxt = (r_dwell != '0) ? S_DWELL_HI : S_DOWN;
      S_DWELL_HI: if (w_dwell_end) w_state_nxt = S_DOWN;
      S_DOWN: begin
        if (w_down_end) begin
          if (w_last)                w_state_nxt = S_IDLE;
          else if (r_dwell != '0)    w_state_nxt = S_DWELL_LO;
          else                       w_state_nxt = S_UP;
        end
      end
      S_DWELL_LO: if (w_dwell_end) w_state_nxt = S_UP;
      default:    w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  always_comb begin
    w_count_nxt     = r_count;
    w_dwell_cnt_nxt = r_dwell_cnt;
    w_sweep_cnt_nxt = r_sweep_cnt;
    w_done_nxt      = 1'b0;
    w_cfg_err_nxt   = 1'b0;
    w_latch         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_latch         = 1'b1;
          w_count_nxt     = cfg_lo;
          w_sweep_cnt_nxt = 8'd0;
        end else if (start) begin
          w_cfg_err_nxt = 1'b1;
        end
      end
      S_UP: begin
        w_count_nxt = w_count_inc;
        if (w_up_end && (r_dwell != '0)) w_dwell_cnt_nxt = r_dwell;
      end
      S_DWELL_HI, S_DWELL_LO: w_dwell_cnt_nxt = r_dwell_cnt - 1'b1;
      S_DOWN: begin
        w_count_nxt = w_count_dec;
        if (w_down_end) begin
          // Saturate so an endless run (sweeps == 0) never wraps the counter.
          w_sweep_cnt_nxt = (r_sweep_cnt == 8'hFF) ? r_sweep_cnt : w_sweep_inc;
          if (w_last)              w_done_nxt      = 1'b1;
          else if (r_dwell != '0)  w_dwell_cnt_nxt = r_dwell;
        end
      end
      default: ;
    endcase
    if (w_abort) begin
      w_count_nxt = r_count;
      w_done_nxt  = 1'b0;
    end
  end

  assign count   = r_count;
  assign down    = r_down;
  assign busy    = r_busy;
  assign done    = r_done;
  assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_sweep_controller.sv
// tb/tb_sweep_controller.sv - directed self-checking bench for sweep_controller.
module tb_sweep_controller;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] cfg_lo, cfg_hi, cfg_sweeps;
  logic [3:0] cfg_dwell;
  logic       start, stop;
  logic [7:0] count;
  logic       down, busy, done, cfg_err;

  int n_vec = 0;
  int n_err = 0;

  sweep_controller #(.WIDTH(8), .DWELL_W(4)) dut (
    .clk(clk), .rstn(rstn), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_dwell(cfg_dwell),
    .cfg_sweeps(cfg_sweeps), .start(start), .stop(stop), .count(count), .down(down),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_lo = 8'd0; cfg_hi = 8'd0; cfg_dwell = 4'd0; cfg_sweeps = 8'd0;
    tick(); tick();
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if ({count, down, busy, done, cfg_err} !== 12'd0) begin
        n_err++;
        $display("FAIL reset_idle c%0d: count=%0d down=%b busy=%b done=%b err=%b, required all 0",
                 c, count, down, busy, done, cfg_err);
      end
      tick();
    end
  endtask

  task automatic test_single_sweep();
    int exp_c [9] = '{2, 3, 4, 5, 5, 5, 4, 3, 2};
    cfg_lo = 8'd2; cfg_hi = 8'd5; cfg_dwell = 4'd2; cfg_sweeps = 8'd1;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      n_vec++;
      if (count !== 8'(exp_c[c-1]) || down !== (c >= 4 && c <= 8) ||
          done !== (c == 9) || busy !== (c < 9)) begin
        n_err++;
        $display("FAIL single_sweep c%0d: count=%0d down=%b done=%b busy=%b, required %0d %b %b %b",
                 c, count, down, done, busy, exp_c[c-1], (c >= 4 && c <= 8), (c == 9), (c < 9));
      end
      if (c < 9) tick();
    end
    tick();
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || count !== 8'd2) begin
      n_err++;
      $display("FAIL single_sweep_after: done=%b busy=%b count=%0d, required 0 0 2", done, busy, count);
    end
  endtask

  task automatic test_multi_sweep();
    int exp_c [13] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0};
    int n_trans = 0;
    logic [7:0] prev;
    cfg_lo = 8'd0; cfg_hi = 8'd3; cfg_dwell = 4'd0; cfg_sweeps = 8'd2;
    start = 1'b1; tick(); start = 1'b0;
    prev = count;
    for (int c = 1; c <= 13; c++) begin
      if (c > 1 && count !== prev) n_trans++;
      prev = count;
      n_vec++;
      if (count !== 8'(exp_c[c-1]) || done !== (c == 13) || busy !== (c < 13)) begin
        n_err++;
        $display("FAIL multi_sweep c%0d: count=%0d done=%b busy=%b, required %0d %b %b",
                 c, count, done, busy, exp_c[c-1], (c == 13), (c < 13));
      end
      if (c < 13) tick();
    end
    n_vec++;
    if (n_trans != 12) begin
      n_err++;
      $display("FAIL multi_sweep_transitions: got %0d, required 12", n_trans);
    end
    tick();
  endtask

  task automatic test_cfg_err();
    cfg_lo = 8'd7; cfg_hi = 8'd7; cfg_dwell = 4'd1; cfg_sweeps = 8'd1;
    start = 1'b1; tick(); start = 1'b0;
    n_vec++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || count !== 8'd0) begin
      n_err++;
      $display("FAIL cfg_err_eq: err=%b busy=%b count=%0d, required 1 0 0", cfg_err, busy, count);
    end
    tick();
    n_vec++;
    if (cfg_err !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL cfg_err_pulse: err=%b busy=%b, required 0 0", cfg_err, busy);
    end
    cfg_lo = 8'd9; cfg_hi = 8'd3;
    start = 1'b1; tick(); start = 1'b0;
    n_vec++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || count !== 8'd0) begin
      n_err++;
      $display("FAIL cfg_err_gt: err=%b busy=%b count=%0d, required 1 0 0", cfg_err, busy, count);
    end
    tick();
  endtask

  task automatic test_abort_isolation();
    bit hit = 0;
    cfg_lo = 8'd10; cfg_hi = 8'd20; cfg_dwell = 4'd0; cfg_sweeps = 8'd0;
    start = 1'b1; tick(); start = 1'b0;
    cfg_hi = 8'd12;
    for (int c = 0; c < 30 && !hit; c++) begin
      if (count === 8'd20) hit = 1;
      else tick();
    end
    n_vec++;
    if (!hit) begin
      n_err++;
      $display("FAIL cfg_isolation: count=%0d after 30 cycles, required to reach 20", count);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || down !== 1'b0 || done !== 1'b0 || count !== 8'd20) begin
      n_err++;
      $display("FAIL stop_at_hi: busy=%b down=%b done=%b count=%0d, required 0 0 0 20",
               busy, down, done, count);
    end
    cfg_hi = 8'd20;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    n_vec++;
    if (count !== 8'd15 || busy !== 1'b1 || down !== 1'b0) begin
      n_err++;
      $display("FAIL pre_stop: count=%0d busy=%b down=%b, required 15 1 0", count, busy, down);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== 8'd15) begin
      n_err++;
      $display("FAIL stop_in_up: busy=%b done=%b count=%0d, required 0 0 15", busy, done, count);
    end
    tick();
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== 8'd15) begin
      n_err++;
      $display("FAIL stop_hold: busy=%b done=%b count=%0d, required 0 0 15", busy, done, count);
    end
  endtask

  task automatic test_async_reset();
    cfg_lo = 8'd2; cfg_hi = 8'd5; cfg_dwell = 4'd4; cfg_sweeps = 8'd1;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    n_vec++;
    if (count !== 8'd5 || down !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL dwell_hi_entry: count=%0d down=%b busy=%b, required 5 1 1", count, down, busy);
    end
    tick();
    #3 rstn = 1'b0;
    #1;
    n_vec++;
    if (count !== 8'd0 || busy !== 1'b0 || down !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: count=%0d busy=%b down=%b, required 0 0 0", count, busy, down);
    end
    tick();
    rstn = 1'b1;
    cfg_lo = 8'd1; cfg_hi = 8'd4; cfg_dwell = 4'd0; cfg_sweeps = 8'd1;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || count !== 8'd1 || down !== 1'b0) begin
      n_err++;
      $display("FAIL start_stop_idle: busy=%b count=%0d down=%b, required 1 1 0", busy, count, down);
    end
    tick();
    n_vec++;
    if (count !== 8'd2 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL start_stop_run: count=%0d busy=%b, required 2 1", count, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_multi_sweep();
    test_cfg_err();
    test_abort_isolation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
